// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller for the dmem bus.
// Rising edges on the per-source request lines are synchronised and latched into
// PENDING. PENDING is masked by ENABLE, and a claim/complete handshake with the cpu
// ensures that only one source is in service at a time.
// Register window (word offsets from BASE_ADDR):
//   +0x0 PENDING (RO), +0x4 ENABLE (RW), +0x8 CLAIM, +0xC COMPLETE.
module irq_ctrl #(
    parameter int          N_SRC     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0410
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_in,
    input  logic [31:0]      addr,
    input  logic [31:0]      w_data,
    input  logic             w_en,
    output logic [31:0]      r_data,
    output logic             hit,
    output logic             int_req
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Lowest set bit wins; returns 0 when nothing is set.
    function automatic logic [3:0] lowest_id(input logic [N_SRC-1:0] vec);
        logic [3:0] id;
        id = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                id = 4'(i);
            end else begin
                id = id;
            end
        end
        return id;
    endfunction

    logic [N_SRC-1:0] sync1_r;
    logic [N_SRC-1:0] sync2_r;
    logic [N_SRC-1:0] prev_r;
    logic [N_SRC-1:0] pending_r;
    logic [N_SRC-1:0] enable_r;
    logic [3:0]       active_id_r;
    state_t           state_r;
    logic             int_req_r;

    state_t           state_next_s;
    logic [31:0]      offset_s;
    logic [1:0]       reg_sel_s;
    logic             hit_s;
    logic             wr_s;
    logic             wr_enable_s;
    logic             wr_claim_s;
    logic             wr_complete_s;
    logic [N_SRC-1:0] edge_s;
    logic [N_SRC-1:0] eligible_s;
    logic             any_eligible_s;
    logic [3:0]       win_id_s;
    logic             claim_s;
    logic             complete_ok_s;
    logic [N_SRC-1:0] clear_s;
    logic [31:0]      pending_ext_s;
    logic [31:0]      enable_ext_s;
    logic [31:0]      r_data_s;

    // Address decode: word-aligned hit inside the 4-word window only.
    always_comb begin
        offset_s  = addr - BASE_ADDR;
        reg_sel_s = offset_s[3:2];
        hit_s     = (offset_s[31:4] == 28'd0) && (offset_s[1:0] == 2'b00);
    end

    // Bus write strobes per register.
    always_comb begin
        wr_s          = w_en & hit_s;
        wr_enable_s   = wr_s && (reg_sel_s == 2'd1);
        wr_claim_s    = wr_s && (reg_sel_s == 2'd2);
        wr_complete_s = wr_s && (reg_sel_s == 2'd3);
    end

    // Edge detection, arbitration and the handshake qualifiers.
    always_comb begin
        edge_s         = sync2_r & ~prev_r;
        eligible_s     = pending_r & enable_r;
        any_eligible_s = |eligible_s;
        win_id_s       = lowest_id(eligible_s);
        claim_s        = (state_r == PEND) && any_eligible_s && wr_claim_s;
        complete_ok_s  = (state_r == SERVICE) && wr_complete_s &&
                         (w_data[3:0] == active_id_r);
    end

    // Clear mask for the claimed source; a same-cycle edge re-sets it afterwards.
    always_comb begin
        clear_s = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clear_s[i] = claim_s && (win_id_s == 4'(i));
        end
    end

    // Two-flop synchroniser and edge history. These run through reset so that
    // prev already holds the synchronised level at release: a source held high
    // across reset therefore produces no edge.
    always_ff @(posedge clock) begin
        sync1_r <= src_in;
        sync2_r <= sync1_r;
        prev_r  <= sync2_r;
    end

    // Next-state logic of the claim/complete sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_eligible_s) begin
                    state_next_s = PEND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PEND: begin
                if (!any_eligible_s) begin
                    state_next_s = IDLE;
                end else if (wr_claim_s) begin
                    state_next_s = SERVICE;
                end else begin
                    state_next_s = PEND;
                end
            end
            SERVICE: begin
                if (complete_ok_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SERVICE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register; int_req is registered from the next state so it equals (state==PEND).
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            int_req_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            int_req_r <= (state_next_s == PEND);
        end
    end

    // PENDING, ENABLE and active_id registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_r   <= '0;
            enable_r    <= '0;
            active_id_r <= 4'd0;
        end else begin
            pending_r <= (pending_r & ~clear_s) | edge_s;
            if (wr_enable_s) begin
                enable_r <= w_data[N_SRC-1:0];
            end
            if (claim_s) begin
                active_id_r <= win_id_s;
            end
        end
    end

    // Zero-extend the source-wide registers to bus width.
    always_comb begin
        pending_ext_s               = 32'd0;
        enable_ext_s                = 32'd0;
        pending_ext_s[N_SRC-1:0]    = pending_r;
        enable_ext_s[N_SRC-1:0]     = enable_r;
    end

    // Side-effect-free read mux; zero outside the window.
    always_comb begin
        r_data_s = 32'd0;
        if (hit_s) begin
            case (reg_sel_s)
                2'd0: r_data_s = pending_ext_s;
                2'd1: r_data_s = enable_ext_s;
                2'd2: begin
                    if ((state_r == PEND) && any_eligible_s) begin
                        r_data_s = {1'b1, 27'd0, win_id_s};
                    end else begin
                        r_data_s = 32'd0;
                    end
                end
                2'd3: r_data_s = {28'd0, active_id_r};
                default: r_data_s = 32'd0;
            endcase
        end else begin
            r_data_s = 32'd0;
        end
    end

    // Drive outputs.
    always_comb begin
        r_data  = r_data_s;
        hit     = hit_s;
        int_req = int_req_r;
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl.
module tb_irq_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0410;

    logic        clock;
    logic        reset;
    logic [3:0]  src_in;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        w_en;
    logic [31:0] r_data;
    logic        hit;
    logic        int_req;

    int errors = 0;
    int checks = 0;
    logic [31:0] rd_v;

    irq_ctrl #(.N_SRC(4), .BASE_ADDR(BASE)) dut (
        .clock  (clock),
        .reset  (reset),
        .src_in (src_in),
        .addr   (addr),
        .w_data (w_data),
        .w_en   (w_en),
        .r_data (r_data),
        .hit    (hit),
        .int_req(int_req)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data);
        addr   = BASE + off;
        w_data = data;
        w_en   = 1'b1;
        tick();
        w_en   = 1'b0;
        w_data = 32'd0;
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] d);
        addr = BASE + off;
        #1;
        d = r_data;
    endtask

    // One-cycle pulse on a source; returns just after edge k (first capture edge).
    task automatic pulse(input int idx);
        src_in[idx] = 1'b1;
        tick();
        src_in[idx] = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        src_in = 4'd0;
        addr   = 32'd0;
        w_data = 32'd0;
        w_en   = 1'b0;
        repeat (4) tick();
        chk("rst_int_req", {31'd0, int_req}, 32'd0);
        chk("rst_hit_out", {31'd0, hit}, 32'd0);
        chk("rst_rdata_out", r_data, 32'd0);
        reset = 1'b0;
        tick();
        rd(32'h0, rd_v); chk("rst_pending", rd_v, 32'd0);
        rd(32'h4, rd_v); chk("rst_enable", rd_v, 32'd0);

        // 1: single source, latency of three edges after capture
        wr(32'h4, 32'h0000_0003);
        rd(32'h4, rd_v); chk("t1_enable", rd_v, 32'h3);
        pulse(1);
        chk("t1_irq_k", {31'd0, int_req}, 32'd0);
        tick();
        chk("t1_irq_k1", {31'd0, int_req}, 32'd0);
        tick();
        chk("t1_irq_k2", {31'd0, int_req}, 32'd0);
        rd(32'h0, rd_v); chk("t1_pending", rd_v, 32'h2);
        tick();
        chk("t1_irq_k3", {31'd0, int_req}, 32'd1);
        rd(32'h8, rd_v); chk("t1_claim", rd_v, 32'h8000_0001);

        // 2: claim then complete
        wr(32'h8, 32'd0);
        chk("t2_irq_claimed", {31'd0, int_req}, 32'd0);
        rd(32'h0, rd_v); chk("t2_pending", rd_v, 32'd0);
        rd(32'hC, rd_v); chk("t2_active", rd_v, 32'd1);
        rd(32'h8, rd_v); chk("t2_claim_svc", rd_v, 32'd0);
        wr(32'hC, 32'd1);
        chk("t2_irq_done", {31'd0, int_req}, 32'd0);
        tick(); tick();
        chk("t2_irq_idle", {31'd0, int_req}, 32'd0);

        // 3: simultaneous sources, fixed priority
        wr(32'h4, 32'h0000_000F);
        src_in = 4'b1001;
        tick();
        src_in = 4'b0000;
        tick(); tick(); tick();
        chk("t3_irq", {31'd0, int_req}, 32'd1);
        rd(32'h8, rd_v); chk("t3_claim0", rd_v, 32'h8000_0000);
        wr(32'h8, 32'd0);
        chk("t3_irq_claimed", {31'd0, int_req}, 32'd0);
        rd(32'h0, rd_v); chk("t3_pending", rd_v, 32'h8);
        wr(32'hC, 32'd0);
        chk("t3_irq_after_cmp", {31'd0, int_req}, 32'd0);
        tick();
        chk("t3_irq_reassert", {31'd0, int_req}, 32'd1);
        rd(32'h8, rd_v); chk("t3_claim3", rd_v, 32'h8000_0003);
        wr(32'h8, 32'd0);
        wr(32'hC, 32'd3);
        rd(32'h0, rd_v); chk("t3_pending_end", rd_v, 32'd0);

        // 4: edge on a disabled source stays pending until enabled
        wr(32'h4, 32'd0);
        pulse(2);
        tick(); tick(); tick();
        chk("t4_irq_dis", {31'd0, int_req}, 32'd0);
        rd(32'h0, rd_v); chk("t4_pending", rd_v, 32'h4);
        wr(32'h4, 32'h0000_0004);
        chk("t4_irq_wr", {31'd0, int_req}, 32'd0);
        tick();
        chk("t4_irq_en", {31'd0, int_req}, 32'd1);
        wr(32'h8, 32'd0);
        wr(32'hC, 32'd2);

        // 5: mismatched complete is ignored; reset mid-service
        wr(32'h4, 32'h0000_0002);
        pulse(1);
        tick(); tick(); tick();
        chk("t5_irq", {31'd0, int_req}, 32'd1);
        wr(32'h8, 32'd0);
        pulse(1);
        tick(); tick(); tick();
        chk("t5_no_nest", {31'd0, int_req}, 32'd0);
        rd(32'h0, rd_v); chk("t5_pending_svc", rd_v, 32'h2);
        wr(32'hC, 32'd2);
        tick(); tick();
        chk("t5_stay_svc", {31'd0, int_req}, 32'd0);
        rd(32'hC, rd_v); chk("t5_active", rd_v, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rst_irq", {31'd0, int_req}, 32'd0);
        rd(32'h0, rd_v); chk("t5_rst_pending", rd_v, 32'd0);
        rd(32'h4, rd_v); chk("t5_rst_enable", rd_v, 32'd0);
        rd(32'hC, rd_v); chk("t5_rst_active", rd_v, 32'd0);
        tick(); tick();
        chk("t5_rst_irq_later", {31'd0, int_req}, 32'd0);

        // 6: source held across reset release, window boundaries
        src_in[0] = 1'b1;
        tick();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        rd(32'h0, rd_v); chk("t6_pending_held", rd_v, 32'd0);
        wr(32'h4, 32'h0000_0001);
        tick();
        chk("t6_irq_held", {31'd0, int_req}, 32'd0);
        wr(32'h0, 32'h0000_000F);
        rd(32'h0, rd_v); chk("t6_pending_ro", rd_v, 32'd0);
        addr = BASE + 32'h10; #1;
        chk("t6_hit_out", {31'd0, hit}, 32'd0);
        chk("t6_rdata_out", r_data, 32'd0);
        addr = BASE + 32'h6; #1;
        chk("t6_hit_unaligned", {31'd0, hit}, 32'd0);
        addr = BASE - 32'h4; #1;
        chk("t6_hit_below", {31'd0, hit}, 32'd0);
        addr = BASE + 32'hC; #1;
        chk("t6_hit_top", {31'd0, hit}, 32'd1);
        src_in[0] = 1'b0;
        repeat (3) tick();
        src_in[0] = 1'b1;
        tick();
        tick(); tick(); tick();
        chk("t6_irq_new_edge", {31'd0, int_req}, 32'd1);
        rd(32'h8, rd_v); chk("t6_claim0", rd_v, 32'h8000_0000);
        src_in[0] = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
